// File: rtl/apb_timer.sv
// APB countdown timer: reloadable down-counter (one-shot/periodic), level interrupt, registered reads.
// Define APB_TIMER_PRESCALE_EN to build the PRESCALE register (0x14) and tick prescaler.
module apb_timer #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  apb_xx_penable,
  input  logic                  apb_xx_pwrite,
  input  logic [ADDR_WIDTH-1:0] apb_xx_paddr,
  input  logic [31:0]           apb_xx_pwdata,
  output logic [31:0]           prdata,
  output logic                  timer_intr
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;

  typedef enum logic [WORD_W-1:0] {
    REG_LOAD    = WORD_W'(0),
    REG_VALUE   = WORD_W'(1),
    REG_CTRL    = WORD_W'(2),
    REG_INTCLR  = WORD_W'(3),
    REG_INTSTAT = WORD_W'(4),
    REG_PRESC   = WORD_W'(5)
  } reg_e;

  logic [WORD_W-1:0]    word;
  logic                 wr_en;
  logic                 rd_cap;
  logic                 wr_load;
  logic                 wr_ctrl;
  logic                 wr_intclr;

  logic [CNT_WIDTH-1:0] load_q;
  logic [CNT_WIDTH-1:0] value_q;
  logic [CNT_WIDTH-1:0] value_d;
  logic                 ctrl_en;
  logic                 ctrl_en_d;
  logic                 ctrl_periodic;
  logic                 ctrl_ie;
  logic                 int_raw;
  logic                 int_raw_d;
  logic                 tick;
  logic                 expire;
  logic                 count;
  logic [31:0]          rdata_d;
  logic                 unused_addr_lsb;

  assign word      = apb_xx_paddr[ADDR_WIDTH-1:2];
  assign wr_en     = psel & apb_xx_penable & apb_xx_pwrite;
  assign rd_cap    = psel & ~apb_xx_penable & ~apb_xx_pwrite;
  assign wr_load   = wr_en & (word == REG_LOAD);
  assign wr_ctrl   = wr_en & (word == REG_CTRL);
  assign wr_intclr = wr_en & (word == REG_INTCLR);

  assign unused_addr_lsb = ^apb_xx_paddr[1:0];

`ifdef APB_TIMER_PRESCALE_EN
  logic       wr_presc;
  logic [7:0] prescale_q;
  logic [7:0] presc_cnt;

  assign wr_presc = wr_en & (word == REG_PRESC);
  assign tick     = (presc_cnt == prescale_q);

  // presc_cnt only advances while enabled, so a stopped timer resumes mid-period
  always_ff @(posedge pclk) begin
    if (prst) begin
      prescale_q <= '0;
      presc_cnt  <= '0;
    end else begin
      if (wr_presc)
        prescale_q <= apb_xx_pwdata[7:0];
      if (wr_load)
        presc_cnt <= '0;
      else if (ctrl_en)
        presc_cnt <= tick ? '0 : presc_cnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign expire = ctrl_en & tick & (value_q == '0);
  assign count  = ctrl_en & tick & (value_q != '0);

  // Priority: LOAD write > decrement/reload; CTRL write > one-shot auto-clear; expiry > INTCLR.
  always_comb begin
    value_d   = value_q;
    ctrl_en_d = ctrl_en;
    int_raw_d = int_raw;

    if (wr_load)
      value_d = apb_xx_pwdata[CNT_WIDTH-1:0];
    else if (count)
      value_d = value_q - CNT_WIDTH'(1);
    else if (expire && ctrl_periodic)
      value_d = load_q;

    if (wr_ctrl)
      ctrl_en_d = apb_xx_pwdata[0];
    else if (expire && !ctrl_periodic)
      ctrl_en_d = 1'b0;

    if (expire)
      int_raw_d = 1'b1;
    else if (wr_intclr)
      int_raw_d = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      load_q        <= '0;
      value_q       <= '0;
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_ie       <= 1'b0;
      int_raw       <= 1'b0;
    end else begin
      if (wr_load)
        load_q <= apb_xx_pwdata[CNT_WIDTH-1:0];
      if (wr_ctrl) begin
        ctrl_periodic <= apb_xx_pwdata[1];
        ctrl_ie       <= apb_xx_pwdata[2];
      end
      value_q <= value_d;
      ctrl_en <= ctrl_en_d;
      int_raw <= int_raw_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (word)
      REG_LOAD:    rdata_d[CNT_WIDTH-1:0] = load_q;
      REG_VALUE:   rdata_d[CNT_WIDTH-1:0] = value_q;
      REG_CTRL:    rdata_d[2:0] = {ctrl_ie, ctrl_periodic, ctrl_en};
      REG_INTSTAT: rdata_d[0] = int_raw;
`ifdef APB_TIMER_PRESCALE_EN
      REG_PRESC:   rdata_d[7:0] = prescale_q;
`endif
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst)
      prdata <= '0;
    else if (rd_cap)
      prdata <= rdata_d;
  end

  assign timer_intr = int_raw & ctrl_ie;

endmodule
